// File: rtl/hsv_core_commit_redirect_if.sv
// Commit record types and the bus that joins the commit stage to execute, regfile and fetch.
package hsv_core_pkg;
  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    COMMIT_NEXT      = 2'd0,
    COMMIT_JUMP      = 2'd1,
    COMMIT_EXCEPTION = 2'd2
  } commit_action_t;

  typedef struct packed {
    word        pc;
    logic [4:0] rd;
  } commit_common_t;

  typedef struct packed {
    commit_action_t action;
    commit_common_t common;
    word            result;
    word            next_pc;
    logic           writeback;
  } commit_data_t;
endpackage

interface hsv_core_commit_redirect_if;
  import hsv_core_pkg::*;

  logic         valid_i;
  logic         ready_o;
  commit_data_t in;
  word          trap_vector;
  logic         wb_en;
  logic [4:0]   wb_rd;
  word          wb_data;
  logic         flush_req;
  logic         redirect_valid;
  word          redirect_pc;
  logic         redirect_ready;
  logic         trap_valid;
  word          trap_epc;
  word          trap_tval;
  logic         retire_o;
  logic [63:0]  instret;

  modport master (
    output valid_i, in, trap_vector, redirect_ready,
    input  ready_o, wb_en, wb_rd, wb_data, flush_req, redirect_valid, redirect_pc,
           trap_valid, trap_epc, trap_tval, retire_o, instret
  );

  modport slave (
    input  valid_i, in, trap_vector, redirect_ready,
    output ready_o, wb_en, wb_rd, wb_data, flush_req, redirect_valid, redirect_pc,
           trap_valid, trap_epc, trap_tval, retire_o, instret
  );
endinterface

// File: rtl/hsv_core_commit_redirect.sv
// Commit stage: retires records, drives regfile writeback, and runs the
// flush/redirect handshake with fetch on jumps and exceptions.
module hsv_core_commit_redirect
  import hsv_core_pkg::*;
(
  input logic                         clk_core,
  input logic                         rst_core_n,
  hsv_core_commit_redirect_if.slave   bus
);

  typedef enum logic [1:0] {RUN, REDIRECT, DRAIN} state_t;

  state_t state, state_nxt;
  logic   accept, is_jump, is_exc, do_retire, do_wb;

  assign bus.ready_o = (state == RUN);

  always_comb begin
    accept    = bus.valid_i && (state == RUN);
    is_exc    = (bus.in.action == COMMIT_EXCEPTION);
    is_jump   = (bus.in.action == COMMIT_JUMP);
    // Unknown encodings fall through to plain retire.
    do_retire = accept && !is_exc;
    do_wb     = do_retire && bus.in.writeback && (bus.in.common.rd != 5'd0);
    state_nxt = state;
    case (state)
      RUN:      if (accept && (is_exc || is_jump)) state_nxt = REDIRECT;
      REDIRECT: if (bus.redirect_ready) state_nxt = DRAIN;
      DRAIN:    state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state              <= RUN;
      bus.wb_en          <= 1'b0;
      bus.wb_rd          <= '0;
      bus.wb_data        <= '0;
      bus.flush_req      <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.trap_valid     <= 1'b0;
      bus.trap_epc       <= '0;
      bus.trap_tval      <= '0;
      bus.retire_o       <= 1'b0;
      bus.instret        <= '0;
    end else begin
      state              <= state_nxt;
      bus.wb_en          <= do_wb;
      bus.retire_o       <= do_retire;
      bus.trap_valid     <= accept && is_exc;
      // Flush/redirect track the next state so they rise with REDIRECT entry.
      bus.flush_req      <= (state_nxt != RUN);
      bus.redirect_valid <= (state_nxt == REDIRECT);
      if (do_wb) begin
        bus.wb_rd   <= bus.in.common.rd;
        bus.wb_data <= bus.in.result;
      end
      if (do_retire) bus.instret <= bus.instret + 64'd1;
      if (accept && is_exc) begin
        bus.trap_epc    <= bus.in.common.pc;
        bus.trap_tval   <= bus.in.next_pc;
        bus.redirect_pc <= {bus.trap_vector[31:2], 2'b00};
      end else if (accept && is_jump) begin
        bus.redirect_pc <= {bus.in.next_pc[31:2], 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_hsv_core_commit_redirect.sv
// Directed bench for hsv_core_commit_redirect with hand-computed expectations.
module tb_hsv_core_commit_redirect;
  import hsv_core_pkg::*;

  logic clk_core = 1'b0;
  logic rst_core_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  hsv_core_commit_redirect_if cr();

  hsv_core_commit_redirect dut (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .bus        (cr.slave)
  );

  always #5 clk_core = ~clk_core;

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] act, input logic [31:0] pc, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] npc, input logic wb);
    cr.valid_i           = 1'b1;
    cr.in.action         = commit_action_t'(act);
    cr.in.common.pc      = pc;
    cr.in.common.rd      = rd;
    cr.in.result         = res;
    cr.in.next_pc        = npc;
    cr.in.writeback      = wb;
  endtask

  initial begin
    cr.valid_i        = 1'b0;
    cr.in             = '0;
    cr.trap_vector    = '0;
    cr.redirect_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_wb_en", cr.wb_en, 0);
    check("rst_flush", cr.flush_req, 0);
    check("rst_rvalid", cr.redirect_valid, 0);
    check("rst_instret", cr.instret, 0);
    check("rst_rpc", cr.redirect_pc, 0);
    rst_core_n = 1'b1;
    tick();
    check("rst_ready", cr.ready_o, 1);

    // NEXT stream
    drive(2'd0, 32'h100, 5'd5, 32'h11, 32'h104, 1'b1);
    tick();
    check("n1_wb_en", cr.wb_en, 1);
    check("n1_wb_rd", cr.wb_rd, 5);
    check("n1_wb_data", cr.wb_data, 32'h11);
    check("n1_retire", cr.retire_o, 1);
    check("n1_ready", cr.ready_o, 1);
    cr.in.result = 32'h22;
    tick();
    check("n2_wb_en", cr.wb_en, 1);
    check("n2_wb_data", cr.wb_data, 32'h22);
    check("n2_ready", cr.ready_o, 1);
    cr.in.result = 32'h33;
    tick();
    cr.valid_i = 1'b0;
    check("n3_wb_en", cr.wb_en, 1);
    check("n3_wb_data", cr.wb_data, 32'h33);
    check("n3_instret", cr.instret, 3);
    tick();
    check("n_idle_wb_en", cr.wb_en, 0);
    check("n_idle_retire", cr.retire_o, 0);

    // rd = 0 suppresses writeback but still retires
    drive(2'd0, 32'h110, 5'd0, 32'h77, 32'h114, 1'b1);
    tick();
    cr.valid_i = 1'b0;
    check("rd0_wb_en", cr.wb_en, 0);
    check("rd0_retire", cr.retire_o, 1);
    check("rd0_instret", cr.instret, 4);

    // Jump with redirect_ready held low for 3 cycles
    drive(2'd1, 32'h120, 5'd7, 32'hAB, 32'h0000_1040, 1'b1);
    tick();
    check("j_wb_en", cr.wb_en, 1);
    check("j_wb_rd", cr.wb_rd, 7);
    check("j_wb_data", cr.wb_data, 32'hAB);
    check("j_rvalid1", cr.redirect_valid, 1);
    check("j_flush1", cr.flush_req, 1);
    check("j_rpc", cr.redirect_pc, 32'h1040);
    check("j_ready1", cr.ready_o, 0);
    check("j_instret", cr.instret, 5);
    // A record offered during the redirect must not be taken
    drive(2'd0, 32'h124, 5'd9, 32'h99, 32'h128, 1'b1);
    tick();
    check("j_rvalid2", cr.redirect_valid, 1);
    check("j_hold_wb", cr.wb_en, 0);
    tick();
    check("j_rvalid3", cr.redirect_valid, 1);
    check("j_rpc3", cr.redirect_pc, 32'h1040);
    tick();
    check("j_rvalid4", cr.redirect_valid, 1);
    check("j_flush4", cr.flush_req, 1);
    cr.redirect_ready = 1'b1;
    tick();
    cr.redirect_ready = 1'b0;
    check("j_drain_rvalid", cr.redirect_valid, 0);
    check("j_drain_flush", cr.flush_req, 1);
    check("j_drain_ready", cr.ready_o, 0);
    check("j_drain_retire", cr.retire_o, 0);
    cr.valid_i = 1'b0;
    tick();
    check("j_run_flush", cr.flush_req, 0);
    check("j_run_ready", cr.ready_o, 1);
    check("j_held_instret", cr.instret, 5);

    // Exception
    cr.trap_vector    = 32'h8000_0003;
    cr.redirect_ready = 1'b1;
    drive(2'd2, 32'h200, 5'd3, 32'h55, 32'h302, 1'b1);
    tick();
    cr.valid_i = 1'b0;
    check("e_trap_valid", cr.trap_valid, 1);
    check("e_epc", cr.trap_epc, 32'h200);
    check("e_tval", cr.trap_tval, 32'h302);
    check("e_rpc", cr.redirect_pc, 32'h8000_0000);
    check("e_wb_en", cr.wb_en, 0);
    check("e_retire", cr.retire_o, 0);
    check("e_instret", cr.instret, 5);
    check("e_rvalid", cr.redirect_valid, 1);
    tick();
    check("e_drain_rvalid", cr.redirect_valid, 0);
    check("e_drain_flush", cr.flush_req, 1);
    check("e_trap_pulse", cr.trap_valid, 0);
    tick();
    cr.redirect_ready = 1'b0;
    check("e_run_ready", cr.ready_o, 1);
    check("e_run_flush", cr.flush_req, 0);

    // Unknown action encoding retires like NEXT
    drive(2'd3, 32'h300, 5'd4, 32'hCAFE, 32'h304, 1'b1);
    tick();
    cr.valid_i = 1'b0;
    check("u_wb_en", cr.wb_en, 1);
    check("u_wb_data", cr.wb_data, 32'hCAFE);
    check("u_rvalid", cr.redirect_valid, 0);
    check("u_instret", cr.instret, 6);

    // Counter wrap
    force cr.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    release cr.instret;
    check("w_preload", cr.instret, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(2'd0, 32'h400, 5'd1, 32'h1, 32'h404, 1'b0);
    tick();
    cr.valid_i = 1'b0;
    check("w_instret", cr.instret, 0);
    check("w_retire", cr.retire_o, 1);
    check("w_wb_en", cr.wb_en, 0);

    // Reset mid-REDIRECT
    drive(2'd1, 32'h500, 5'd0, 32'h0, 32'h0000_2000, 1'b0);
    tick();
    cr.valid_i = 1'b0;
    check("r_rvalid_pre", cr.redirect_valid, 1);
    #2;
    rst_core_n = 1'b0;
    #1;
    check("r_async_rvalid", cr.redirect_valid, 0);
    check("r_async_flush", cr.flush_req, 0);
    check("r_async_rpc", cr.redirect_pc, 0);
    tick();
    rst_core_n = 1'b1;
    tick();
    check("r_ready", cr.ready_o, 1);
    check("r_wb_en", cr.wb_en, 0);
    check("r_wb_rd", cr.wb_rd, 0);
    check("r_wb_data", cr.wb_data, 0);
    check("r_trap_epc", cr.trap_epc, 0);
    check("r_trap_tval", cr.trap_tval, 0);
    check("r_instret", cr.instret, 0);
    check("r_flush", cr.flush_req, 0);
    check("r_rvalid", cr.redirect_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
